la_dump_uart_tx: RTL and testbench

Drain engine for the logic-analyser capture path: on command, reads a fixed number of sample bytes from the capture FIFO written by `my_logic_analysis`, frames them into a packet, and serialises the packet as UART 8N1 toward the host. It sits between the capture FIFO read port and the board TX pin. It is the transmitting end of the capture link whose receiving end is the host/UART receiver.

---
 rtl/la_dump_uart_tx_if.sv | 10 +
 rtl/la_dump_uart_tx.sv | 134 +++++++++++++
 tb/tb_la_dump_uart_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/la_dump_uart_tx_if.sv
// Capture-FIFO read port: drain engine pulls one byte per fifo_ren, data valid the next clock.
// The engine never reads while fifo_empty is high; the FIFO side applies backpressure only via that flag.
interface la_dump_uart_tx_if;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_ren;

    modport master (output fifo_ren, input fifo_rdata, input fifo_empty);
    modport slave  (input fifo_ren, output fifo_rdata, output fifo_empty);
endinterface

// File: rtl/la_dump_uart_tx.sv
// Drains dump_len capture bytes and sends A5, len_hi, len_lo, data..., csum as UART 8N1 frames.
// Start bit one clock after dump_start; an empty FIFO stalls in FETCH with tx idle-high, no timeout.
module la_dump_uart_tx (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [12:0]               uart_ctrl_tx,
    input  logic                      dump_start,
    input  logic [15:0]               dump_len,
    la_dump_uart_tx_if.master         fifo,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_FETCH, S_WAIT, S_DATA, S_CSUM, S_FIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len_q;
    logic [15:0] rem;
    logic [12:0] div_q;
    logic [7:0]  csum;
    logic [9:0]  shreg;
    logic [12:0] baud;
    logic [3:0]  bit_idx;
    logic        active;
    logic        frame_end;
    logic        load;
    logic [7:0]  load_byte;

    // True during the final clock of a stop bit.
    assign frame_end = active && (baud == div_q) && (bit_idx == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dump_start) state_nxt = S_HDR0;
            S_HDR0:  if (frame_end) state_nxt = S_HDR1;
            S_HDR1:  if (frame_end) state_nxt = S_HDR2;
            S_HDR2:  if (frame_end) state_nxt = (rem != 16'd0) ? S_FETCH : S_CSUM;
            S_FETCH: if (!fifo.fifo_empty) state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_DATA;
            S_DATA:  if (frame_end) state_nxt = (rem != 16'd0) ? S_FETCH : S_CSUM;
            S_CSUM:  if (frame_end) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame loads coincide with state changes so the start bit appears with no gap.
    always_comb begin
        busy          = (state != S_IDLE) && (state != S_FIN);
        done          = (state == S_FIN);
        fifo.fifo_ren = (state == S_FETCH) && !fifo.fifo_empty;
        load          = 1'b0;
        load_byte     = 8'h00;
        case (state)
            S_IDLE: if (dump_start) begin
                load      = 1'b1;
                load_byte = 8'hA5;
            end
            S_HDR0: if (frame_end) begin
                load      = 1'b1;
                load_byte = len_q[15:8];
            end
            S_HDR1: if (frame_end) begin
                load      = 1'b1;
                load_byte = len_q[7:0];
            end
            S_HDR2, S_DATA: if (frame_end && (rem == 16'd0)) begin
                load      = 1'b1;
                load_byte = csum;
            end
            S_WAIT: begin
                load      = 1'b1;
                load_byte = fifo.fifo_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= 16'd0;
            rem   <= 16'd0;
            div_q <= 13'd0;
            csum  <= 8'd0;
        end else if ((state == S_IDLE) && dump_start) begin
            len_q <= dump_len;
            rem   <= dump_len;
            div_q <= uart_ctrl_tx;
            csum  <= 8'd0;
        end else if (state == S_WAIT) begin
            rem   <= rem - 16'd1;
            csum  <= csum + fifo.fifo_rdata;
        end
    end

    // Shifting in ones leaves the register all-high after the stop bit, so tx idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '1;
            baud    <= 13'd0;
            bit_idx <= 4'd0;
            active  <= 1'b0;
        end else if (load) begin
            shreg   <= {1'b1, load_byte, 1'b0};
            baud    <= 13'd0;
            bit_idx <= 4'd0;
            active  <= 1'b1;
        end else if (active) begin
            if (baud == div_q) begin
                baud  <= 13'd0;
                shreg <= {1'b1, shreg[9:1]};
                if (bit_idx == 4'd9) begin
                    bit_idx <= 4'd0;
                    active  <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                baud <= baud + 13'd1;
            end
        end
    end

    assign tx = shreg[0];
endmodule

// File: tb/tb_la_dump_uart_tx.sv
// Directed bench: FIFO model feeding the drain engine and a UART 8N1 decoder on tx.
module tb_la_dump_uart_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] uart_ctrl_tx;
    logic        dump_start;
    logic [15:0] dump_len;
    logic        tx, busy, done;

    la_dump_uart_tx_if fif();

    la_dump_uart_tx dut (
        .clk(clk), .rst_n(rst_n), .uart_ctrl_tx(uart_ctrl_tx), .dump_start(dump_start),
        .dump_len(dump_len), .fifo(fif), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Capture FIFO model: data one clock after fifo_ren; optional forced-empty window after a chosen read.
    logic [7:0] fmem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int stall_ptr = -1;
    int stall_len = 0;
    int stall_cnt = 0;

    assign fif.fifo_empty = (rd_ptr == wr_ptr) || (stall_cnt != 0);

    always @(posedge clk) begin
        if (fif.fifo_ren) begin
            fif.fifo_rdata <= fmem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
            if (stall_len != 0 && rd_ptr + 1 == stall_ptr) stall_cnt <= stall_len;
        end else if (stall_cnt != 0) begin
            stall_cnt <= stall_cnt - 1;
        end
    end

    // UART decoder and activity counters, sampled 1 time unit after each rising edge.
    int         mon_div = 4;
    int         mon_p = 0;
    logic       mon_on = 1'b0;
    logic [9:0] mon_bits;
    logic [7:0] rx_buf [0:63];
    int rx_n = 0, mon_err = 0, busy_cyc = 0, ren_cnt = 0, done_cnt = 0;
    int stall_seen = 0, stall_viol = 0;

    always @(posedge clk) begin
        int k, r;
        #1;
        if (busy) busy_cyc++;
        if (fif.fifo_ren) ren_cnt++;
        if (done) done_cnt++;
        if (stall_cnt >= 1 && stall_cnt <= 100) begin
            stall_seen++;
            if (tx !== 1'b1 || fif.fifo_ren !== 1'b0) stall_viol++;
        end
        if (!rst_n) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (tx === 1'b0) begin
                mon_on = 1'b1;
                mon_p = 0;
                mon_bits[0] = 1'b0;
            end
        end else begin
            mon_p++;
            k = mon_p / (mon_div + 1);
            r = mon_p % (mon_div + 1);
            if (r == 0) mon_bits[k] = tx;
            if (r == mon_div && tx !== mon_bits[k]) mon_err++;
            if (k == 9 && r == mon_div) begin
                if (mon_bits[9] !== 1'b1) mon_err++;
                if (rx_n < 64) rx_buf[rx_n] = mon_bits[8:1];
                rx_n++;
                mon_on = 1'b0;
            end
        end
    end

    int s_rx, s_busy, s_ren, s_done, s_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    task automatic snap();
        s_rx = rx_n; s_busy = busy_cyc; s_ren = ren_cnt; s_done = done_cnt; s_err = mon_err;
    endtask

    task automatic start_dump(input logic [15:0] len, input logic [12:0] div);
        @(negedge clk);
        dump_len = len;
        uart_ctrl_tx = div;
        mon_div = int'(div);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({tag, "_end"}, done, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic post(input string tag, input int n, input logic [63:0] exp,
                        input int bcyc, input int rens);
        chk({tag, "_nbytes"}, rx_n - s_rx, n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), rx_buf[s_rx + i], exp[8*(n-1-i) +: 8]);
        chk({tag, "_busy_len"}, busy_cyc - s_busy, bcyc);
        chk({tag, "_ren"}, ren_cnt - s_ren, rens);
        chk({tag, "_done"}, done_cnt - s_done, 1);
        chk({tag, "_frame"}, mon_err - s_err, 0);
    endtask

    initial begin
        int ss, sv;
        rst_n = 1'b0;
        dump_start = 1'b0;
        dump_len = 16'd0;
        uart_ctrl_tx = 13'd4;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", fif.fifo_ren, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tx", tx, 1);

        // Empty dump: A5 00 00 00, no reads.
        snap();
        start_dump(16'd0, 13'd4);
        wait_done("len0", 500);
        post("len0", 4, 64'hA5000000, 200, 0);

        // Three data bytes.
        push(8'h21); push(8'h37); push(8'h21);
        snap();
        start_dump(16'd3, 13'd4);
        wait_done("len3", 1000);
        post("len3", 7, 64'hA5000321372179, 356, 3);

        // FIFO held empty for 100 FETCH cycles before the second byte.
        push(8'h21); push(8'h37); push(8'h21);
        stall_ptr = rd_ptr + 1;
        stall_len = 151;
        ss = stall_seen; sv = stall_viol;
        snap();
        start_dump(16'd3, 13'd4);
        wait_done("stall", 1000);
        stall_len = 0;
        post("stall", 7, 64'hA5000321372179, 456, 3);
        chk("stall_cycles", stall_seen - ss, 100);
        chk("stall_idle", stall_viol - sv, 0);

        // Mid-packet dump_start and divisor change are ignored.
        push(8'h21); push(8'h37); push(8'h21);
        snap();
        fork
            begin
                start_dump(16'd3, 13'd4);
                wait_done("ignore", 1000);
            end
            begin
                repeat (120) @(negedge clk);
                dump_len = 16'd7;
                uart_ctrl_tx = 13'd9;
                dump_start = 1'b1;
                @(negedge clk);
                dump_start = 1'b0;
            end
        join
        uart_ctrl_tx = 13'd4;
        post("ignore", 7, 64'hA5000321372179, 356, 3);

        // Reset during data bit 4 of the first data frame.
        push(8'h21); push(8'h37); push(8'h21);
        snap();
        start_dump(16'd3, 13'd4);
        for (int i = 0; i < 1000; i++) begin
            if (fif.fifo_ren) break;
            @(negedge clk);
        end
        chk("rstmid_ren_seen", fif.fifo_ren, 1);
        repeat (29) @(negedge clk);
        chk("rstmid_pre_tx", tx, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_tx", tx, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ren", fif.fifo_ren, 0);
        chk("rstmid_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_ptr = rd_ptr;
        @(negedge clk);
        chk("rstmid_partial", rx_n - s_rx, 3);

        // Fresh packet after reset, different divisor.
        push(8'h55);
        snap();
        start_dump(16'd1, 13'd2);
        wait_done("div2", 500);
        post("div2", 5, 64'hA500015555, 152, 1);

        // dump_start during FIN is ignored, accepted the following cycle.
        start_dump(16'd0, 13'd1);
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        snap();
        dump_start = 1'b1;
        @(negedge clk);
        chk("fin_ignored", busy, 0);
        @(negedge clk);
        dump_start = 1'b0;
        chk("after_fin_busy", busy, 1);
        chk("after_fin_start_bit", tx, 0);
        wait_done("refire", 300);
        post("refire", 4, 64'hA5000000, 80, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
